// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Optional build macro EARLY_TERM_EN is consumed by seq_shift_add_multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold a down-counter that starts at n and ends at 0.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: shifted multiplicand, shifting multiplier and accumulator.
// The controller issues load (capture operands) and step (one radix-2 iteration).
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [M-1:0]     a,
    input  logic [N-1:0]     b,
    output logic [M+N-1:0]   acc_next,
    output logic             b_last
);

    localparam int PW = M + N;

    logic [PW-1:0] a_sh;
    logic [N-1:0]  b_sh;
    logic [PW-1:0] acc;

    // Operand capture on load, one shift-add iteration per step.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            acc  <= '0;
        end else if (load) begin
            a_sh <= {{N{1'b0}}, a};
            b_sh <= b;
            acc  <= '0;
        end else if (step) begin
            acc  <= acc_next;
            a_sh <= a_sh << 1;
            b_sh <= b_sh >> 1;
        end
    end

    // Accumulator value after the current iteration; the full-width sum cannot overflow.
    assign acc_next = b_sh[0] ? acc + a_sh : acc;

    // No set multiplier bits remain once the current bit has been consumed.
    assign b_last = ((b_sh >> 1) == '0);

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned M x N multiplier, one multiplier bit per clock,
// with valid/ready handshakes on operands and product.
// Build macro EARLY_TERM_EN: leave CALC as soon as the remaining multiplier
// bits are all zero (B==0 goes straight to DONE); products are unchanged.
module seq_shift_add_multiplier
    import seq_mult_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     A,
    input  logic [N-1:0]     B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M+N-1:0]   P
);

    localparam int PW = M + N;
    localparam int CW = cnt_width(N);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic            load;
    logic            step;
    logic            calc_exit;
    logic [PW-1:0]   acc_next;
    logic            b_last;

    seq_mult_datapath #(
        .M (M),
        .N (N)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .a        (A),
        .b        (B),
        .acc_next (acc_next),
        .b_last   (b_last)
    );

`ifdef EARLY_TERM_EN
    assign calc_exit = (cnt == CW'(1)) || b_last;
`else
    logic unused_b_last;
    assign unused_b_last = b_last;
    assign calc_exit     = (cnt == CW'(1));
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath control decode.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = CALC;
`ifdef EARLY_TERM_EN
                    if (B == '0) begin
                        state_next = DONE;
                    end
`endif
                end
            end
            CALC: begin
                step = 1'b1;
                if (calc_exit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Iteration counter and product register; P only changes on the edge entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            P   <= '0;
        end else begin
            if (load) begin
                cnt <= CW'(N);
            end else if (step) begin
                cnt <= cnt - 1'b1;
            end
            if (step && calc_exit) begin
                P <= acc_next;
`ifdef EARLY_TERM_EN
            end else if (load && (B == '0)) begin
                P <= '0;
`endif
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: a 3x2 instance swept
// exhaustively and an 8x8 instance driven with directed vectors.
// Honors EARLY_TERM_EN for the expected latency of each product.
module tb_seq_shift_add_multiplier;

    typedef struct {
        int p;
        int cap;
        int lat;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // 8x8 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] p;

    // 3x2 instance
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [2:0]  s_a;
    logic [1:0]  s_b;
    logic [4:0]  s_p;

    exp_t q_big[$];
    exp_t q_small[$];
    bit   seen_big = 0;
    bit   seen_small = 0;

    seq_shift_add_multiplier #(.M(8), .N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (a),
        .B         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (p)
    );

    seq_shift_add_multiplier #(.M(3), .N(2)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .A         (s_a),
        .B         (s_b),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .P         (s_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Edges from the capture edge until out_valid is seen.
    function automatic int exp_lat(input int n, input logic [31:0] bv);
        int hi = 0;
        for (int i = 0; i < 32; i++) if (bv[i]) hi = i + 1;
`ifdef EARLY_TERM_EN
        return hi;
`else
        return (hi > n) ? -1 : n;
`endif
    endfunction

    task automatic drive_big(input logic [7:0] av, input logic [7:0] bv, input int exp_p);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a = av;
        b = bv;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("big_accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        q_big.push_back('{p: exp_p, cap: cyc + 1, lat: exp_lat(8, 32'(bv))});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~av;
        b = ~bv;
    endtask

    task automatic drive_small(input int av, input int bv);
        int waited = 0;
        @(negedge clk);
        s_in_valid = 1'b1;
        s_a = 3'(av);
        s_b = 2'(bv);
        while (!s_in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!s_in_ready) begin
            check("small_accept_timeout", 0, 1);
            s_in_valid = 1'b0;
            return;
        end
        q_small.push_back('{p: av * bv, cap: cyc + 1, lat: exp_lat(2, 32'(bv))});
        @(posedge clk);
        #1;
        s_in_valid = 1'b0;
        s_a = ~s_a;
        s_b = ~s_b;
    endtask

    initial begin
        int w;
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0;

        // Scoreboard monitor: latency on first sight of out_valid, product on handshake.
        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (out_valid) begin
                        if (q_big.size() == 0) begin
                            check("big_spurious_valid", 1, 0);
                        end else begin
                            if (!seen_big) begin
                                check("big_latency", cyc - q_big[0].cap, q_big[0].lat);
                                seen_big = 1;
                            end
                            if (out_ready) begin
                                check("big_product", 32'(p), q_big[0].p);
                                void'(q_big.pop_front());
                                seen_big = 0;
                            end
                        end
                    end
                    if (s_out_valid) begin
                        if (q_small.size() == 0) begin
                            check("small_spurious_valid", 1, 0);
                        end else begin
                            if (!seen_small) begin
                                check("small_latency", cyc - q_small[0].cap, q_small[0].lat);
                                seen_small = 1;
                            end
                            if (s_out_ready) begin
                                check("small_product", 32'(s_p), q_small[0].p);
                                void'(q_small.pop_front());
                                seen_small = 0;
                            end
                        end
                    end
                end
            end
        join_none

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_p", 32'(p), 0);
        check("rst_s_in_ready", 32'(s_in_ready), 1);
        check("rst_s_out_valid", 32'(s_out_valid), 0);
        check("rst_s_p", 32'(s_p), 0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive 3x2 sweep (e.g. 7*3 -> 21)
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                drive_small(ai, bi);
            end
        end

        // 8x8 corner vectors
        drive_big(8'd255, 8'd255, 65025);
        drive_big(8'd0,   8'd200, 0);
        drive_big(8'd1,   8'd128, 128);

        // Backpressure: product held while out_ready is low
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        drive_big(8'd13, 8'd11, 143);
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_valid_seen", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_p_held", 32'(p), 143);
            check("bp_in_ready_low", 32'(in_ready), 0);
            check("bp_valid_held", 32'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_after", 32'(in_ready), 1);
        check("bp_valid_dropped", 32'(out_valid), 0);

        // Operands offered while busy wait for IDLE
        drive_big(8'd5, 8'd6, 30);
        @(negedge clk);
        check("busy_in_ready_low", 32'(in_ready), 0);
        drive_big(8'd9, 8'd9, 81);

        // Reset mid-CALC discards the in-flight product
        drive_big(8'd100, 8'd50, 5000);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_p", 32'(p), 0);
        q_big.delete();
        seen_big = 0;
        @(negedge clk);
        rst = 1'b0;
        drive_big(8'd4, 8'd4, 16);

`ifdef EARLY_TERM_EN
        // Early termination latencies: B=1 -> 1, B=0 -> 0 after capture, B=128 -> 8
        drive_big(8'd200, 8'd1,   200);
        drive_big(8'd77,  8'd0,   0);
        drive_big(8'd3,   8'd128, 384);
`endif

        // Drain outstanding expectations
        w = 0;
        while ((q_big.size() + q_small.size()) != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_pending", 32'(q_big.size() + q_small.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
